// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//
// Receive-side reader placed behind the UART receiver on the same clock. Each
// rising edge of Rx_VALID with clean error flags pushes Rx_DATA into a small
// first-word-fall-through FIFO. Frames flagged with a framing or parity error
// are dropped and counted in a saturating error counter. The consumer pops one
// entry per cycle with Rd_EN.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   Rx_DATA     received byte
//   Rx_VALID    byte-valid level (may stay high for many cycles)
//   Rx_FERROR   framing error flag
//   Rx_PERROR   parity error flag
//   Rd_EN       pop request, one entry per cycle while not empty
//   Clr         synchronous clear of Rd_OVERRUN and Err_COUNT
//   Rd_DATA     head entry while not empty, 8'h00 while empty
//   Rd_EMPTY    FIFO holds no entries
//   Rd_FULL     FIFO holds 2^DEPTH_LOG2 entries
//   Rd_COUNT    number of stored entries
//   Rd_OVERRUN  sticky: a clean byte arrived while full and was dropped
//   Err_COUNT   saturating count of error events
// -----------------------------------------------------------------------------
module uart_rx_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            Rx_DATA,
    input  logic                  Rx_VALID,
    input  logic                  Rx_FERROR,
    input  logic                  Rx_PERROR,
    input  logic                  Rd_EN,
    input  logic                  Clr,
    output logic [7:0]            Rd_DATA,
    output logic                  Rd_EMPTY,
    output logic                  Rd_FULL,
    output logic [DEPTH_LOG2:0]   Rd_COUNT,
    output logic                  Rd_OVERRUN,
    output logic [7:0]            Err_COUNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(32'd1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(32'd0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(32'd1);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    // Storage and pointers
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;

    // Previous-cycle copies of the valid level and the combined error level.
    // They reset to 1 so a level already high at reset release is not an edge.
    logic                  vld_q_r;
    logic                  err_q_r;

    // Registered outputs
    logic [7:0]            data_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  overrun_r;
    logic [7:0]            err_cnt_r;

    // Event decode
    logic                  err_lvl_s;
    logic                  vld_rise_s;
    logic                  data_ev_s;
    logic                  err_ev_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    // Next-state values
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic [7:0]            data_nxt_s;
    logic                  empty_nxt_s;
    logic                  full_nxt_s;
    logic                  overrun_nxt_s;
    logic [7:0]            err_cnt_nxt_s;

    // Edge detection and classification of receiver events
    always_comb begin
        err_lvl_s  = Rx_FERROR | Rx_PERROR;
        vld_rise_s = Rx_VALID & ~vld_q_r;
        data_ev_s  = vld_rise_s & ~err_lvl_s;
        // A new error level and a valid edge under an error flag in the same
        // cycle are one event, hence the OR.
        err_ev_s   = (err_lvl_s & ~err_q_r) | (vld_rise_s & err_lvl_s);
        pop_s      = Rd_EN & ~empty_r;
        // When full, a same-cycle pop frees the slot being written.
        push_s     = data_ev_s & (~full_r | pop_s);
        drop_s     = data_ev_s & full_r & ~pop_s;
    end

    // Next-state computation for pointers, occupancy, head data and flags
    always_comb begin
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        count_nxt_s   = count_r;
        data_nxt_s    = 8'h00;
        overrun_nxt_s = overrun_r;
        err_cnt_nxt_s = err_cnt_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Head seen after the edge: the byte being written becomes the head
        // when nothing older survives this cycle; otherwise the head is an
        // already-stored entry, which this cycle's write never overwrites.
        if (count_nxt_s == CNT_ZERO) begin
            data_nxt_s = 8'h00;
        end else if (push_s && ((count_r == CNT_ZERO) ||
                                (pop_s && (count_r == CNT_ONE)))) begin
            data_nxt_s = Rx_DATA;
        end else begin
            data_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        empty_nxt_s = (count_nxt_s == CNT_ZERO);
        full_nxt_s  = (count_nxt_s == CNT_DEPTH);

        // Clear wins over a same-cycle overrun or error event.
        if (Clr) begin
            overrun_nxt_s = 1'b0;
            err_cnt_nxt_s = 8'h00;
        end else begin
            if (drop_s) begin
                overrun_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s = overrun_r;
            end
            if (err_ev_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_nxt_s = err_cnt_r + 8'h01;
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
        end
    end

    // Control state and registered outputs; reset empties the FIFO at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= CNT_ZERO;
            vld_q_r   <= 1'b1;
            err_q_r   <= 1'b1;
            data_r    <= 8'h00;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
            err_cnt_r <= 8'h00;
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            vld_q_r   <= Rx_VALID;
            err_q_r   <= err_lvl_s;
            data_r    <= data_nxt_s;
            empty_r   <= empty_nxt_s;
            full_r    <= full_nxt_s;
            overrun_r <= overrun_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    // Storage array write; contents are don't-care until pointed to
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= Rx_DATA;
        end
    end

    assign Rd_DATA    = data_r;
    assign Rd_EMPTY   = empty_r;
    assign Rd_FULL    = full_r;
    assign Rd_COUNT   = count_r;
    assign Rd_OVERRUN = overrun_r;
    assign Err_COUNT  = err_cnt_r;

endmodule
